// File: rtl/seq_controller.sv
// seq_controller: ring-counter sequencer for a small accumulator machine.
// Decodes the one-hot T-state and the opcode into active-high control strobes.
// Optional feature: define SEQ_SHORT_CYCLE_EN to end LDA after T5, and OUT or
// undefined opcodes after T4. ADD/SUB always take six states. HLT always stops in T4.
module seq_controller (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       mem_enable,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic       halt,
  output logic [5:0] t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  t_state_e r_state;
  t_state_e w_state_next;
  logic     r_halt;
  logic     w_halt_next;

  logic w_is_lda;
  logic w_is_alu;
  logic w_is_out;
  logic w_is_hlt;

  assign w_is_lda = (opcode == OP_LDA);
  assign w_is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign w_is_out = (opcode == OP_OUT);
  assign w_is_hlt = (opcode == OP_HLT);

  assign t_state = r_state;

  // State and halt registers: reset returns to T1 and releases halt from any state.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= T1;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_halt  <= w_halt_next;
    end
  end

  // Next-state logic: the ring advances unless halted; HLT freezes the ring in T4.
  always_comb begin
    w_state_next = r_state;
    w_halt_next  = r_halt;
    if (!r_halt) begin
      case (r_state)
        T1: w_state_next = T2;
        T2: w_state_next = T3;
        T3: w_state_next = T4;
        T4: begin
          if (w_is_hlt) begin
            w_state_next = T4;
            w_halt_next  = 1'b1;
          end else begin
`ifdef SEQ_SHORT_CYCLE_EN
            // OUT and undefined opcodes have no work left after T4.
            w_state_next = (w_is_lda || w_is_alu) ? T5 : T1;
`else
            w_state_next = T5;
`endif
          end
        end
        T5: begin
`ifdef SEQ_SHORT_CYCLE_EN
          w_state_next = w_is_lda ? T1 : T6;
`else
          w_state_next = T6;
`endif
        end
        T6:      w_state_next = T1;
        default: w_state_next = T1;
      endcase
    end
  end

  // Control decode: reset masks every output, and a halted machine shows only halt.
  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    mar_load   = 1'b0;
    mem_enable = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    alu_sub    = 1'b0;
    alu_out    = 1'b0;
    out_load   = 1'b0;
    halt       = 1'b0;
    if (clr_n) begin
      if (r_halt) begin
        halt = 1'b1;
      end else begin
        case (r_state)
          T1: begin
            pc_out   = 1'b1;
            mar_load = 1'b1;
          end
          T2: pc_inc = 1'b1;
          T3: begin
            mem_enable = 1'b1;
            ir_load    = 1'b1;
          end
          T4: begin
            if (w_is_lda || w_is_alu) begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end else if (w_is_out) begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end else if (w_is_hlt) begin
              halt = 1'b1;
            end
          end
          T5: begin
            if (w_is_lda) begin
              mem_enable = 1'b1;
              a_load     = 1'b1;
            end else if (w_is_alu) begin
              mem_enable = 1'b1;
              b_load     = 1'b1;
            end
          end
          T6: begin
            if (w_is_alu) begin
              alu_out = 1'b1;
              a_load  = 1'b1;
              alu_sub = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: per-cycle scoreboard check of seq_controller.
// Expectations come from a table-style model of the instruction set.
// The model follows SEQ_SHORT_CYCLE_EN when the bench is built with it.
module tb_seq_controller;

  logic       clk;
  logic       clr_n;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, mar_load, mem_enable, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_sub, alu_out, out_load, halt;
  logic [5:0] t_state;

  seq_controller dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .opcode     (opcode),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .mar_load   (mar_load),
    .mem_enable (mem_enable),
    .ir_load    (ir_load),
    .ir_out     (ir_out),
    .a_load     (a_load),
    .a_out      (a_out),
    .b_load     (b_load),
    .alu_sub    (alu_sub),
    .alu_out    (alu_out),
    .out_load   (out_load),
    .halt       (halt),
    .t_state    (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  t;
    logic [12:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_t     = 1;      // model T-state index, 1..6
  bit   m_halt  = 1'b0;   // model halt register

  // Control vector order:
  // {pc_out,pc_inc,mar_load,mem_enable,ir_load,ir_out,a_load,a_out,b_load,alu_sub,alu_out,out_load,halt}
  logic [12:0] dut_ctrl;
  assign dut_ctrl = {pc_out, pc_inc, mar_load, mem_enable, ir_load, ir_out,
                     a_load, a_out, b_load, alu_sub, alu_out, out_load, halt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] exp_ctrl(input int t, input logic [3:0] op,
                                           input logic clr, input bit hreg);
    logic p_o, p_i, mar, mem, irl, iro, al, ao, bl, sub, alo, ol, h;
    {p_o, p_i, mar, mem, irl, iro, al, ao, bl, sub, alo, ol, h} = '0;
    if (clr) begin
      if (hreg) h = 1'b1;
      else begin
        case (t)
          1: begin p_o = 1; mar = 1; end
          2: p_i = 1;
          3: begin mem = 1; irl = 1; end
          4: case (op)
               4'h0, 4'h1, 4'h2: begin iro = 1; mar = 1; end
               4'hE: begin ao = 1; ol = 1; end
               4'hF: h = 1;
               default: ;
             endcase
          5: case (op)
               4'h0: begin mem = 1; al = 1; end
               4'h1, 4'h2: begin mem = 1; bl = 1; end
               default: ;
             endcase
          6: if (op == 4'h1 || op == 4'h2) begin
               alo = 1; al = 1; sub = (op == 4'h2);
             end
          default: ;
        endcase
      end
    end
    return {p_o, p_i, mar, mem, irl, iro, al, ao, bl, sub, alo, ol, h};
  endfunction

  // Model state update at a rising edge.
  task automatic model_edge(input logic [3:0] op, input logic clr);
    if (!clr) begin
      m_t = 1; m_halt = 1'b0;
    end else if (m_halt) begin
      m_t = 4;
    end else if (m_t == 4 && op == 4'hF) begin
      m_halt = 1'b1;
    end else begin
`ifdef SEQ_SHORT_CYCLE_EN
      if (m_t == 4 && !(op == 4'h0 || op == 4'h1 || op == 4'h2)) m_t = 1;
      else if (m_t == 5 && op == 4'h0) m_t = 1;
      else m_t = (m_t == 6) ? 1 : m_t + 1;
`else
      m_t = (m_t == 6) ? 1 : m_t + 1;
`endif
    end
  endtask

  // One clock cycle: drive, push expectation, compare at negedge, take the edge.
  task automatic cycle(input string ph, input logic [3:0] op, input logic clr, input bit chk);
    exp_t e;
    exp_t got;
    int   nb;
    opcode = op;
    clr_n  = clr;
    if (chk) begin
      e.t = 6'(1 << (m_t - 1));
      e.c = exp_ctrl(m_t, op, clr, m_halt);
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (chk) begin
      got = sb_q.pop_front();
      nb  = int'(pc_out) + int'(mem_enable) + int'(ir_out) + int'(a_out) + int'(alu_out);
      $display("[TB] %s op=%h clr_n=%b t_state=%h ctrl=%h", ph, op, clr, t_state, dut_ctrl);
      check($sformatf("%s t_state", ph), 32'(t_state), 32'(got.t));
      check($sformatf("%s ctrl", ph), 32'(dut_ctrl), 32'(got.c));
      check($sformatf("%s bus_le1", ph), 32'(nb <= 1), 32'd1);
    end
    @(posedge clk);
    model_edge(op, clr);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode = 4'h0;
    clr_n  = 1'b0;
    @(posedge clk);
    #1;
    // Reset: the first edge is not checked because t_state is unknown before it.
    cycle("rst0", 4'h0, 1'b0, 1'b0);
    cycle("rst", 4'h0, 1'b0, 1'b1);
    // LDA, ADD, SUB, OUT, undefined opcodes, one instruction each.
    for (int i = 0; i < 6; i++) cycle("lda", 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("add", 4'h1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("sub", 4'h2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("out", 4'hE, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("nop5", 4'h5, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("nopC", 4'hC, 1'b1, 1'b1);
    // Reset during T5 of an ADD, then continue with ADD.
    cycle("sync", 4'h1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("add_pre", 4'h1, 1'b1, 1'b1);
    cycle("add_rst", 4'h1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle("add_post", 4'h1, 1'b1, 1'b1);
    // HLT: stays halted in T4, then a single reset edge releases it.
    cycle("sync", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle("hlt", 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle("hlt_other", 4'h1, 1'b1, 1'b1);
    cycle("hlt_rst", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle("lda2", 4'h0, 1'b1, 1'b1);
    // Random opcodes and occasional resets.
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), 1'b1);
    end
    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 opcode  input  4  instruction opcode (IR upper nibble); valid from T4 onward.
REQ-005 pc_out  output  1  program counter drives w_bus.
REQ-006 pc_inc  output  1  program counter increments at next edge.
REQ-007 mar_load  output  1  memory address register loads from w_bus.
REQ-008 mem_enable  output  1  memory drives w_bus at the MAR address.
REQ-009 ir_load / ir_out  output  1 each  instruction register load / drive low nibble onto w_bus.
REQ-010 a_load / a_out  output  1 each  accumulator load / drive w_bus.
REQ-011 b_load  output  1  B register load.
REQ-012 alu_sub / alu_out  output  1 each  ALU subtract select / ALU drives w_bus.
REQ-013 out_load  output  1  output register load.
REQ-014 halt  output  1  sticky halt indication; the clock gate is external.
REQ-015 t_state  output  6  one-hot ring state; bit0 = T1 ... bit5 = T6.

Function
REQ-016 The ring counter SHALL advance T1->T2->...->T6->T1, one state per clk edge, while halt=0.
REQ-017 Control outputs SHALL be combinational decode of the registered t_state and opcode, active-high, zero latency.
REQ-018 T1 SHALL assert pc_out and mar_load; T2 SHALL assert pc_inc; T3 SHALL assert mem_enable and ir_load, for every opcode.
REQ-019 LDA (0000) SHALL decode as: T4 ir_out and mar_load; T5 mem_enable and a_load; T6 no controls.
REQ-020 ADD (0001) SHALL decode as: T4 ir_out and mar_load; T5 mem_enable and b_load; T6 alu_out and a_load, with alu_sub=0.
REQ-021 SUB (0010) SHALL decode identically to ADD, except that alu_sub=1 in T6.
REQ-022 OUT (1110) SHALL decode as: T4 a_out and out_load; T5 and T6 no controls.
REQ-023 HLT (1111) in T4 SHALL assert halt combinationally and SHALL set a halt register at that edge.
REQ-024 While the halt register is set, t_state SHALL hold T4, halt SHALL stay 1, and all other controls SHALL be 0 until reset.
REQ-025 Any undefined opcode SHALL execute as a NOP: no controls in T4-T6, and normal wrap to T1.
REQ-026 At most one bus driver (pc_out, mem_enable, ir_out, a_out, alu_out) SHALL be asserted in any state.

Reset
REQ-027 While clr_n=0, all control outputs and halt SHALL be forced to 0.
REQ-028 The first clk edge with clr_n=0 SHALL set t_state=000001 (T1) and clear the halt register.
REQ-029 Reset SHALL take effect in any state, including mid-instruction and while halted, and SHALL abandon the current instruction.
REQ-030 In the first cycle after clr_n returns high, the block SHALL be in T1 with pc_out=1 and mar_load=1.

Configuration
REQ-031 Macro SEQ_SHORT_CYCLE_EN SHALL control variable-length machine cycles.
REQ-032 With SEQ_SHORT_CYCLE_EN defined, LDA SHALL return T5->T1, OUT and undefined opcodes SHALL return T4->T1, and ADD/SUB SHALL remain 6 states.
REQ-033 With SEQ_SHORT_CYCLE_EN undefined, every instruction SHALL take exactly 6 states.

Verification
REQ-034 Reset, then LDA (opcode=0000) held for 6 clocks -> t_state sequence 01,02,04,08,10,20 hex; pc_out+mar_load in T1; mem_enable+a_load in T5.
REQ-035 SUB (opcode=0010) -> alu_sub=1, alu_out=1, a_load=1 only in T6 (t_state=20); alu_sub=0 in every other state.
REQ-036 HLT (opcode=1111) -> halt=1 from T4; t_state holds 08 for 10+ clocks with all other controls 0; clr_n=0 for 1 edge -> halt=0, t_state=01.
REQ-037 clr_n=0 asserted during T5 of an ADD -> all controls 0 in that cycle; after the edge, t_state=01; no b_load pulse at the next T5-position edge.
REQ-038 OUT (opcode=1110) with SEQ_SHORT_CYCLE_EN defined -> 4-state cycle (01,02,04,08,01); without the macro -> 6 states; a_out+out_load in T4 in both builds.
REQ-039 Every state across all opcodes, checked per cycle -> count of asserted bus drivers is at most 1; undefined opcode 0101 -> T4-T6 all controls 0.
